// File: rtl/bp_fe_fetch_sequencer.sv
// Fetch PC sequencer: several outstanding I$ fetches, in-order tags, result buffer.
// Define BP_FE_FETCH_SEQUENCER_RVC_EN for a 2-byte step and halfword alignment.
module bp_fe_fetch_sequencer #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int inflight_p = 4,
  parameter logic [vaddr_width_p-1:0] boot_pc_p = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     redirect_v_i,
  input  logic [vaddr_width_p-1:0] redirect_pc_i,
  output logic                     fetch_v_o,
  output logic [vaddr_width_p-1:0] fetch_pc_o,
  input  logic                     fetch_ready_i,
  input  logic                     resp_v_i,
  input  logic [instr_width_p-1:0] resp_data_i,
  input  logic                     resp_fault_i,
  output logic                     queue_v_o,
  output logic [vaddr_width_p-1:0] queue_pc_o,
  output logic [instr_width_p-1:0] queue_instr_o,
  output logic [1:0]               queue_exc_o,
  input  logic                     queue_ready_i
);

  localparam int ptr_w_lp = $clog2(inflight_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(inflight_p);
  localparam logic [cnt_w_lp:0] lim_lp = (cnt_w_lp+1)'(inflight_p);
`ifdef BP_FE_FETCH_SEQUENCER_RVC_EN
  localparam logic [vaddr_width_p-1:0] step_lp = vaddr_width_p'(2);
`else
  localparam logic [vaddr_width_p-1:0] step_lp = vaddr_width_p'(4);
`endif

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_WAIT} state_e;

  state_e state_q, state_d;
  logic [vaddr_width_p-1:0] pc_q, pc_d;
  logic [cnt_w_lp-1:0] out_q, out_d;
  logic [cnt_w_lp-1:0] drop_q, drop_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic [ptr_w_lp-1:0] tag_wr_q, tag_wr_d;
  logic [ptr_w_lp-1:0] tag_rd_q, tag_rd_d;
  logic [ptr_w_lp-1:0] buf_wr_q, buf_wr_d;
  logic [ptr_w_lp-1:0] buf_rd_q, buf_rd_d;

  logic [vaddr_width_p-1:0] tag_pc_q [inflight_p];
  logic [vaddr_width_p-1:0] buf_pc_q [inflight_p];
  logic [instr_width_p-1:0] buf_instr_q [inflight_p];
  logic [1:0]               buf_exc_q [inflight_p];

  logic aligned, hs, pop, resp_keep, drain_push, buf_we;
  logic [cnt_w_lp-1:0] live;
  logic [cnt_w_lp:0] sum;
  logic [vaddr_width_p-1:0] wr_pc;
  logic [instr_width_p-1:0] wr_instr;
  logic [1:0] wr_exc;

  always_comb begin
`ifdef BP_FE_FETCH_SEQUENCER_RVC_EN
    aligned = ~pc_q[0];
`else
    aligned = (pc_q[1:0] == 2'b00);
`endif
    live = out_q - drop_q;
    sum = {1'b0, out_q} + {1'b0, cnt_q};
    fetch_v_o = (state_q == S_RUN) & aligned
              & ~redirect_v_i & (sum < lim_lp);
    fetch_pc_o = pc_q;
    queue_v_o = (cnt_q != '0);
    hs = fetch_v_o & fetch_ready_i;
    pop = queue_v_o & queue_ready_i;
    // Stale (pre-redirect) and post-exception responses never reach the buffer
    resp_keep = resp_v_i & (drop_q == '0)
              & (state_q != S_WAIT) & ~redirect_v_i;
    drain_push = (state_q == S_DRAIN) & (live == '0)
               & (cnt_q < full_lp) & ~redirect_v_i;
    buf_we = resp_keep | drain_push;
    wr_pc = drain_push ? pc_q : tag_pc_q[tag_rd_q];
    wr_instr = (drain_push | resp_fault_i) ? '0 : resp_data_i;
    wr_exc = drain_push ? 2'b01 : (resp_fault_i ? 2'b10 : 2'b00);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (resp_keep & resp_fault_i) state_d = S_WAIT;
        else if (~aligned) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (resp_keep & resp_fault_i) state_d = S_WAIT;
        else if (drain_push) state_d = S_WAIT;
      end
      S_WAIT: state_d = S_WAIT;
      default: state_d = S_RUN;
    endcase
    if (redirect_v_i) state_d = S_RUN;
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_v_i) pc_d = redirect_pc_i;
    else if (hs) pc_d = pc_q + step_lp;
    out_d = out_q + cnt_w_lp'(hs) - cnt_w_lp'(resp_v_i);
    drop_d = drop_q;
    if (redirect_v_i) drop_d = out_q - cnt_w_lp'(resp_v_i);
    else if (resp_v_i && drop_q != '0) drop_d = drop_q - cnt_w_lp'(1);
    cnt_d = cnt_q + cnt_w_lp'(buf_we) - cnt_w_lp'(pop);
    buf_rd_d = buf_rd_q + ptr_w_lp'(pop);
    if (redirect_v_i) begin
      cnt_d = '0;
      buf_rd_d = buf_wr_q;
    end
    buf_wr_d = buf_wr_q + ptr_w_lp'(buf_we);
    tag_wr_d = tag_wr_q + ptr_w_lp'(hs);
    tag_rd_d = tag_rd_q + ptr_w_lp'(resp_v_i);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_RUN;
      pc_q <= boot_pc_p;
      out_q <= '0;
      drop_q <= '0;
      cnt_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      buf_wr_q <= '0;
      buf_rd_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
      cnt_q <= cnt_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      buf_wr_q <= buf_wr_d;
      buf_rd_q <= buf_rd_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < inflight_p; i++) begin
        tag_pc_q[i] <= '0;
        buf_pc_q[i] <= '0;
        buf_instr_q[i] <= '0;
        buf_exc_q[i] <= '0;
      end
    end else begin
      if (hs) tag_pc_q[tag_wr_q] <= pc_q;
      if (buf_we) begin
        buf_pc_q[buf_wr_q] <= wr_pc;
        buf_instr_q[buf_wr_q] <= wr_instr;
        buf_exc_q[buf_wr_q] <= wr_exc;
      end
    end
  end

  assign queue_pc_o = buf_pc_q[buf_rd_q];
  assign queue_instr_o = buf_instr_q[buf_rd_q];
  assign queue_exc_o = buf_exc_q[buf_rd_q];

  resp_has_req_a: assert property (
    @(posedge clk_i) disable iff (reset_i)
    resp_v_i |-> (out_q != '0));

endmodule
